// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, decoder FSM states and small helpers
// used by the vga_sync_decoder slice.
package vga_timing_pkg;

    localparam int H_TOTAL_DEF  = 800;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_TOTAL_DEF  = 525;
    localparam int V_ACTIVE_DEF = 480;
    localparam int H_SYNC       = 96;
    localparam int V_SYNC       = 2;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SYNCING  = 2'd1,
        LOCKED   = 2'd2
    } sync_state_e;

    // Saturating add of a 0..3 event count onto an 8-bit counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, acc} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// VGA stream bundle: sync, blanking strobe and colour, driven by the timing
// generator (master) and observed by the decoder (slave).
interface vga_sync_decoder_if;
    logic       hs;
    logic       vs;
    logic       rdn;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;

    modport master (output hs, vs, rdn, r, g, b);
    modport slave  (input  hs, vs, rdn, r, g, b);
endinterface

// File: rtl/vga_sync_decoder_crc16.sv
// vga_crc16: one 12-bit MSB-first CRC-16-CCITT step, used only when
// VGA_SYNC_DECODER_CRC_EN is defined.
`ifdef VGA_SYNC_DECODER_CRC_EN
module vga_crc16
    import vga_timing_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [11:0] data_i,
    output logic [15:0] crc_o
);
    logic [15:0] c_s;

    // Unrolled bit-serial shift over the twelve data bits.
    always_comb begin
        c_s = crc_i;
        for (int i = 11; i >= 0; i--) begin
            if (c_s[15] ^ data_i[i]) begin
                c_s = {c_s[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c_s = {c_s[14:0], 1'b0};
            end
        end
        crc_o = c_s;
    end
endmodule
`endif

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from a VGA stream, checks line/frame
// timing and reports lock. Define VGA_SYNC_DECODER_CRC_EN to build frame_crc.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              vga_clk,
    input  logic              clrn,
    vga_sync_decoder_if.slave vga,
    output logic              pix_valid,
    output logic [8:0]        pix_row,
    output logic [9:0]        pix_col,
    output logic [11:0]       pix_rgb,
    output logic              frame_start,
    output logic              locked,
    output logic              h_err,
    output logic              a_err,
    output logic              v_err,
    output logic [7:0]        err_cnt,
    output logic [15:0]       frame_crc
);
    logic        hs_q, vs_q, rdn_q, hs_p_q, vs_p_q, rdn_p_q;
    logic [11:0] rgb_q;
    logic        hs_fall_s, vs_fall_s, rdn_rise_s, checking_s, err_any_s;
    logic [9:0]  h_cnt_q, h_cnt_d, col_q, col_d, col_base_s;
    logic [9:0]  row_q, row_d, line_cnt_q, line_cnt_d;
    logic [10:0] line_len_s;
    logic [8:0]  pix_row_d;
    logic        h_err_d, a_err_d, v_err_d;
    logic [7:0]  err_cnt_d;
    logic        pix_valid_q, frame_start_q, h_err_q, a_err_q, v_err_q, locked_q;
    logic [8:0]  pix_row_q;
    logic [9:0]  pix_col_q;
    logic [11:0] pix_rgb_q;
    logic [7:0]  err_cnt_q;
    sync_state_e state_q;
    logic [3:0]  clean_q;

    // Stage 1: register pins and keep the previous sample for edge detection.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            rdn_q   <= 1'b1;
            rgb_q   <= 12'd0;
            hs_p_q  <= 1'b1;
            vs_p_q  <= 1'b1;
            rdn_p_q <= 1'b1;
        end else begin
            hs_q    <= vga.hs;
            vs_q    <= vga.vs;
            rdn_q   <= vga.rdn;
            rgb_q   <= {vga.b, vga.g, vga.r};
            hs_p_q  <= hs_q;
            vs_p_q  <= vs_q;
            rdn_p_q <= rdn_q;
        end
    end

    // Edge detection, counter next-state and timing checks on stage-1 values.
    always_comb begin
        hs_fall_s  = hs_p_q & ~hs_q;
        vs_fall_s  = vs_p_q & ~vs_q;
        rdn_rise_s = ~rdn_p_q & rdn_q;
        checking_s = (state_q != UNLOCKED);

        h_cnt_d = 10'd0;
        if (!hs_fall_s) begin
            h_cnt_d = (h_cnt_q == 10'h3FF) ? h_cnt_q : h_cnt_q + 10'd1;
        end else begin
            h_cnt_d = 10'd0;
        end

        col_base_s = hs_fall_s ? 10'd0 : col_q;
        col_d      = (!rdn_q && col_base_s != 10'h3FF) ? col_base_s + 10'd1 : col_base_s;

        row_d = row_q;
        if (vs_fall_s) begin
            row_d = 10'd0;
        end else if (rdn_rise_s && row_q != 10'h3FF) begin
            row_d = row_q + 10'd1;
        end else begin
            row_d = row_q;
        end
        pix_row_d = vs_fall_s ? 9'd0 : row_q[8:0];

        // A line whose hs falls together with vs still belongs to the closing frame.
        line_len_s = {1'b0, line_cnt_q} + {10'd0, hs_fall_s};
        line_cnt_d = line_cnt_q;
        if (vs_fall_s) begin
            line_cnt_d = 10'd0;
        end else if (hs_fall_s && line_cnt_q != 10'h3FF) begin
            line_cnt_d = line_cnt_q + 10'd1;
        end else begin
            line_cnt_d = line_cnt_q;
        end

        h_err_d = checking_s & hs_fall_s & (({1'b0, h_cnt_q} + 11'd1) != 11'(H_TOTAL));
        a_err_d = checking_s & rdn_rise_s & (col_q != 10'(H_ACTIVE));
        v_err_d = checking_s & vs_fall_s &
                  ((line_len_s != 11'(V_TOTAL)) | (row_q != 10'(V_ACTIVE)));
        err_cnt_d = sat_add8(err_cnt_q, {1'b0, h_err_d} + {1'b0, a_err_d} + {1'b0, v_err_d});
    end

    // Line/frame counters.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            h_cnt_q    <= 10'd0;
            col_q      <= 10'd0;
            row_q      <= 10'd0;
            line_cnt_q <= 10'd0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    // Stage 2: registered pixel, pulse and error-count outputs.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            pix_valid_q   <= 1'b0;
            pix_row_q     <= 9'd0;
            pix_col_q     <= 10'd0;
            pix_rgb_q     <= 12'd0;
            frame_start_q <= 1'b0;
            h_err_q       <= 1'b0;
            a_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            pix_valid_q   <= ~rdn_q;
            pix_row_q     <= pix_row_d;
            pix_col_q     <= col_base_s;
            pix_rgb_q     <= rgb_q;
            frame_start_q <= vs_fall_s;
            h_err_q       <= h_err_d;
            a_err_q       <= a_err_d;
            v_err_q       <= v_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign err_any_s = h_err_q | a_err_q | v_err_q;

    // Lock FSM reacts to the visible pulses, so locked trails an error by one cycle.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= UNLOCKED;
            clean_q  <= 4'd0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                UNLOCKED: begin
                    if (frame_start_q) begin
                        state_q <= SYNCING;
                        clean_q <= 4'd0;
                    end
                end
                SYNCING: begin
                    if (err_any_s) begin
                        clean_q <= 4'd0;
                    end else if (frame_start_q) begin
                        clean_q <= clean_q + 4'd1;
                        if ((clean_q + 4'd1) == 4'(LOCK_FRAMES)) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (err_any_s) begin
                        state_q  <= SYNCING;
                        clean_q  <= 4'd0;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= UNLOCKED;
                    clean_q  <= 4'd0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_SYNC_DECODER_CRC_EN
    logic [15:0] crc_q, crc_next_s, frame_crc_q;

    vga_crc16 u_crc (
        .crc_i  (crc_q),
        .data_i (rgb_q),
        .crc_o  (crc_next_s)
    );

    // Running CRC over active pixels, latched and re-seeded at each frame start.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            crc_q       <= CRC_INIT;
            frame_crc_q <= 16'd0;
        end else if (vs_fall_s) begin
            crc_q       <= CRC_INIT;
            frame_crc_q <= crc_q;
        end else if (!rdn_q) begin
            crc_q       <= crc_next_s;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = 16'd0;
`endif

    assign pix_valid   = pix_valid_q;
    assign pix_row     = pix_row_q;
    assign pix_col     = pix_col_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign h_err       = h_err_q;
    assign a_err       = a_err_q;
    assign v_err       = v_err_q;
    assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster (40x20 clocks,
// 24x12 active) so that many frames fit in a short run.
module tb_vga_sync_decoder;
    localparam int H_TOT = 40, H_ACT = 24, HS_START = 28, HS_LEN = 6;
    localparam int V_TOT = 20, V_ACT = 12, VS_START = 14, VS_LEN = 2;
    localparam int FRAME = H_TOT * V_TOT;

    logic        vga_clk = 1'b0;
    logic        clrn    = 1'b0;
    logic        pix_valid, frame_start, locked, h_err, a_err, v_err;
    logic [8:0]  pix_row;
    logic [9:0]  pix_col;
    logic [11:0] pix_rgb;
    logic [7:0]  err_cnt;
    logic [15:0] frame_crc;

    vga_sync_decoder_if bus ();

    vga_sync_decoder #(
        .H_TOTAL(H_TOT), .H_ACTIVE(H_ACT), .V_TOTAL(V_TOT), .V_ACTIVE(V_ACT), .LOCK_FRAMES(2)
    ) dut (
        .vga_clk(vga_clk), .clrn(clrn), .vga(bus),
        .pix_valid(pix_valid), .pix_row(pix_row), .pix_col(pix_col), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked), .h_err(h_err), .a_err(a_err),
        .v_err(v_err), .err_cnt(err_cnt), .frame_crc(frame_crc)
    );

    always #20 vga_clk = ~vga_clk;

    typedef struct {
        int          v;
        int          h;
        logic        valid;
        logic [8:0]  row;
        logic [9:0]  col;
        logic [11:0] rgb;
        logic        chk_pos;
    } vec_t;

    vec_t vecs[10];
    int   tests = 0, fails = 0;
    int   h = 0, v = 0, drv_h = 0, drv_v = 0;
    int   stretch_line = -1, short_line = -1, drop_line = -1;
    logic white = 1'b0;
    int   fs_seen = 0, h_seen = 0, a_seen = 0, v_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One pixel clock: sample outputs and count pulses, then drive the next position.
    task automatic step();
        int hlen, alen;
        @(negedge vga_clk);
        fs_seen += int'(frame_start);
        h_seen  += int'(h_err);
        a_seen  += int'(a_err);
        v_seen  += int'(v_err);
        alen = (v == short_line)   ? H_ACT - 1 : H_ACT;
        hlen = (v == stretch_line) ? H_TOT + 1 : H_TOT;
        bus.hs  = !(h >= HS_START && h < HS_START + HS_LEN);
        bus.vs  = !(v >= VS_START && v < VS_START + VS_LEN);
        bus.rdn = !(v < V_ACT && h < alen);
        if (white) begin
            {bus.b, bus.g, bus.r} = 12'hFFF;
        end else begin
            bus.b = 4'(v);
            bus.g = 4'(h >> 4);
            bus.r = 4'(h);
        end
        drv_h = h;
        drv_v = v;
        if (h >= hlen - 1) begin
            h = 0;
            v = (v >= V_TOT - 1) ? 0 : v + 1;
            if (v == drop_line) v = v + 1;
        end else begin
            h = h + 1;
        end
    endtask

    task automatic run_until_fs(input int target, input string name);
        int n;
        n = 0;
        while (fs_seen < target && n < 3 * FRAME) begin
            step();
            n++;
        end
        check({name, "_frame_start"}, 64'(fs_seen), 64'(target));
    endtask

    task automatic run_to(input int tv, input int th, input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(drv_v == tv && drv_h == th) && n < 2 * FRAME);
        check({name, "_reached"}, 64'(drv_v == tv && drv_h == th), 64'd1);
    endtask

`ifdef VGA_SYNC_DECODER_CRC_EN
    function automatic logic [15:0] crc_white_frame(input int npix);
        logic [15:0] c;
        logic [11:0] d;
        logic        fb;
        c = 16'hFFFF;
        d = 12'hFFF;
        for (int p = 0; p < npix; p++) begin
            for (int i = 11; i >= 0; i--) begin
                fb = c[15] ^ d[i];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction
`endif

    initial begin
        int base_fs, base_err;
        bus.hs = 1'b1; bus.vs = 1'b1; bus.rdn = 1'b1;
        bus.r = 4'd0; bus.g = 4'd0; bus.b = 4'd0;

        vecs[0] = '{0,  0,  1'b1, 9'd0,  10'd0,  12'h000, 1'b1};
        vecs[1] = '{0,  5,  1'b1, 9'd0,  10'd5,  12'h005, 1'b1};
        vecs[2] = '{0,  23, 1'b1, 9'd0,  10'd23, 12'h017, 1'b1};
        vecs[3] = '{0,  26, 1'b0, 9'd0,  10'd0,  12'h000, 1'b0};
        vecs[4] = '{1,  0,  1'b1, 9'd1,  10'd0,  12'h100, 1'b1};
        vecs[5] = '{5,  10, 1'b1, 9'd5,  10'd10, 12'h50A, 1'b1};
        vecs[6] = '{11, 0,  1'b1, 9'd11, 10'd0,  12'hB00, 1'b1};
        vecs[7] = '{11, 23, 1'b1, 9'd11, 10'd23, 12'hB17, 1'b1};
        vecs[8] = '{12, 3,  1'b0, 9'd0,  10'd0,  12'h000, 1'b0};
        vecs[9] = '{15, 0,  1'b0, 9'd0,  10'd0,  12'h000, 1'b0};

        repeat (3) @(negedge vga_clk);
        check("reset_outputs", 64'({pix_valid, pix_row, pix_col, pix_rgb, frame_start, locked,
                                    h_err, a_err, v_err, err_cnt, frame_crc}), 64'd0);
        clrn = 1'b1;

        // Pixel recovery over the first frame, 2-clock latency from the pins.
        for (int i = 0; i < 10; i++) begin
            run_to(vecs[i].v, vecs[i].h, $sformatf("vec%0d", i));
            step();
            step();
            check($sformatf("vec%0d_valid", i), 64'(pix_valid), 64'(vecs[i].valid));
            if (vecs[i].chk_pos) begin
                check($sformatf("vec%0d_row", i), 64'(pix_row), 64'(vecs[i].row));
                check($sformatf("vec%0d_col", i), 64'(pix_col), 64'(vecs[i].col));
                check($sformatf("vec%0d_rgb", i), 64'(pix_rgb), 64'(vecs[i].rgb));
            end
        end

        // Lock on the third vs fall, no errors on a clean stream.
        run_until_fs(3, "lock");
        check("locked_before_3rd", 64'(locked), 64'd0);
        step();
        check("locked_after_3rd", 64'(locked), 64'd1);
        check("clean_err_pulses", 64'(h_seen + a_seen + v_seen), 64'd0);
        check("clean_err_cnt", 64'(err_cnt), 64'd0);

        // One 41-clock line.
        stretch_line = 5;
        run_until_fs(4, "stretch");
        stretch_line = -1;
        check("stretch_h_err", 64'(h_seen), 64'd1);
        check("stretch_other_err", 64'(a_seen + v_seen), 64'd0);
        check("stretch_err_cnt", 64'(err_cnt), 64'd1);
        check("stretch_unlocked", 64'(locked), 64'd0);
        run_until_fs(5, "relock");
        step();
        check("relock_after_2", 64'(locked), 64'd1);

        // One active run one pixel short.
        short_line = 3;
        run_until_fs(6, "short");
        short_line = -1;
        check("short_a_err", 64'(a_seen), 64'd1);
        check("short_no_v_err", 64'(v_seen), 64'd0);
        check("short_no_h_err", 64'(h_seen), 64'd1);
        check("short_err_cnt", 64'(err_cnt), 64'd2);
        check("short_unlocked", 64'(locked), 64'd0);

        // One blanking line dropped.
        drop_line = 17;
        run_until_fs(7, "drop");
        drop_line = -1;
        check("drop_v_err", 64'(v_seen), 64'd1);
        check("drop_v_err_now", 64'(v_err), 64'd1);
        check("drop_err_cnt", 64'(err_cnt), 64'd3);

        // Asynchronous reset in the middle of an active line.
        run_to(3, 10, "midline");
        clrn = 1'b0;
        #1;
        check("midline_reset_outputs", 64'({pix_valid, pix_row, pix_col, pix_rgb, frame_start, locked,
                                            h_err, a_err, v_err, err_cnt, frame_crc}), 64'd0);
        step();
        step();
        clrn = 1'b1;
        base_fs  = fs_seen;
        base_err = h_seen + a_seen + v_seen;
        run_until_fs(base_fs + 1, "post_reset_sync");
        check("post_reset_no_err", 64'(h_seen + a_seen + v_seen), 64'(base_err));
        check("post_reset_err_cnt", 64'(err_cnt), 64'd0);
        run_until_fs(base_fs + 3, "post_reset_lock");
        check("post_reset_locked_before", 64'(locked), 64'd0);
        step();
        check("post_reset_locked_after", 64'(locked), 64'd1);
        check("post_reset_err_cnt_end", 64'(err_cnt), 64'd0);

`ifdef VGA_SYNC_DECODER_CRC_EN
        white = 1'b1;
        run_until_fs(base_fs + 4, "crc_a");
        check("crc_white_a", 64'(frame_crc), 64'(crc_white_frame(H_ACT * V_ACT)));
        run_until_fs(base_fs + 5, "crc_b");
        check("crc_white_b", 64'(frame_crc), 64'(crc_white_frame(H_ACT * V_ACT)));
        white = 1'b0;
`else
        run_until_fs(base_fs + 4, "crc_off");
        check("crc_disabled", 64'(frame_crc), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
